// File: rtl/fifo_param_pkg.sv
// Shared types for the parametrised FIFO: the per-cycle operation derived
// from the enqueue/dequeue handshakes.
package fifo_param_pkg;

   // Encoded as {deq_fire, enq_fire} so a plain cast maps handshakes onto it.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_ENQ  = 2'b01,
      OP_DEQ  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic enq_fire, input logic deq_fire);
      return fifo_op_e'({deq_fire, enq_fire});
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular index 0..DEPTH-1 with explicit wrap, so DEPTH need not be a power of 2.
module fifo_wrap_ptr #(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with val/rdy handshakes, occupancy count,
// almost-full/almost-empty flags and synchronous flush. Outputs depend on registers only.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq_val,
   input  logic [WIDTH-1:0]           enq_data,
   output logic                       enq_rdy,
   output logic                       deq_val,
   output logic [WIDTH-1:0]           deq_data,
   input  logic                       deq_rdy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_param: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_param: AE_THRESH must be in 0..DEPTH-1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             enq_fire;
   logic             deq_fire;

   // Flush wins over both handshakes: whatever is presented that cycle is dropped.
   assign enq_fire = enq_val & enq_rdy & ~flush;
   assign deq_fire = deq_val & deq_rdy & ~flush;

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (enq_fire),
      .ptr   (wr_ptr)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (deq_fire),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (enq_fire)
         mem[wr_ptr] <= enq_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (flush)
         count <= '0;
      else begin
         case (fifo_op(enq_fire, deq_fire))
            OP_ENQ:  count <= count + CW'(1);
            OP_DEQ:  count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign enq_rdy      = (count != CW'(DEPTH));
   assign deq_val      = (count != '0);
   assign deq_data     = deq_val ? mem[rd_ptr] : '0;
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

endmodule

// File: tb/tb_fifo_param.sv
// Randomised and directed bench for fifo_param: a DEPTH=4 and a DEPTH=5 instance,
// each checked every cycle against a queue-based occupancy model and scoreboard.
module tb_fifo_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  flush, enq_val, deq_rdy;
   logic [31:0] enq_data [2];
   logic [1:0]  enq_rdy, deq_val, almost_full, almost_empty;
   logic [31:0] deq_data [2];
   logic [2:0]  count [2];

   int          ncmp = 0;
   int          nerr = 0;
   bit          started = 0;
   int          mcount [2];
   logic [31:0] sb0 [$];
   logic [31:0] sb1 [$];
   logic [31:0] got0 [$];
   logic [31:0] got1 [$];

   always #10 clk = ~clk;

   fifo_param #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut4 (
      .clk(clk), .reset(reset), .flush(flush[0]),
      .enq_val(enq_val[0]), .enq_data(enq_data[0]), .enq_rdy(enq_rdy[0]),
      .deq_val(deq_val[0]), .deq_data(deq_data[0]), .deq_rdy(deq_rdy[0]),
      .count(count[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0])
   );

   fifo_param #(.WIDTH(32), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) dut5 (
      .clk(clk), .reset(reset), .flush(flush[1]),
      .enq_val(enq_val[1]), .enq_data(enq_data[1]), .enq_rdy(enq_rdy[1]),
      .deq_val(deq_val[1]), .deq_data(deq_data[1]), .deq_rdy(deq_rdy[1]),
      .count(count[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1])
   );

   function automatic int dep(input int k);
      return (k == 0) ? 4 : 5;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Expected popped stream is base, base+stp, ... (n entries); consumes the record.
   task automatic chk_got(input string nm, input int k, input int n, input logic [31:0] base,
                          input logic [31:0] stp);
      int sz;
      sz = (k == 0) ? got0.size() : got1.size();
      chk({nm, "_len"}, k, sz, n);
      for (int i = 0; i < n && i < sz; i++)
         chk(nm, k, (k == 0) ? got0[i] : got1[i], base + stp * i);
      if (k == 0) got0.delete(); else got1.delete();
   endtask

   // Drive one cycle on dut k, then advance the model by what that edge should do.
   task automatic step(input int k, input bit ev, input logic [31:0] ed, input bit dr,
                       input bit fl, output bit acc);
      bit dq;
      enq_val = '0; deq_rdy = '0; flush = '0;
      enq_val[k] = ev; deq_rdy[k] = dr; flush[k] = fl; enq_data[k] = ed;
      @(posedge clk);
      acc = ev && !fl && (mcount[k] < dep(k));
      dq  = dr && !fl && (mcount[k] > 0);
      if (fl) begin
         mcount[k] = 0;
         if (k == 0) sb0.delete(); else sb1.delete();
      end else begin
         if (acc) begin
            if (k == 0) sb0.push_back(ed); else sb1.push_back(ed);
         end
         mcount[k] = mcount[k] + int'(acc) - int'(dq);
      end
      #1;
   endtask

   // Monitor: compare every visible output against the model; pop on a consumed head.
   always @(negedge clk) begin
      if (started && !reset) begin
         for (int k = 0; k < 2; k++) begin
            int          mc;
            bit          has;
            logic [31:0] head;
            mc   = mcount[k];
            has  = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            head = has ? ((k == 0) ? sb0[0] : sb1[0]) : 32'd0;
            chk("count", k, count[k], mc);
            chk("deq_val", k, deq_val[k], mc != 0);
            chk("enq_rdy", k, enq_rdy[k], mc != dep(k));
            chk("almost_full", k, almost_full[k], mc >= 3);
            chk("almost_empty", k, almost_empty[k], mc <= 1);
            chk("deq_data", k, deq_data[k], (mc != 0) ? head : 32'd0);
            if (deq_val[k] && deq_rdy[k] && !flush[k]) begin
               if (!has) begin
                  chk("pop_underflow", k, 1, 0);
               end else if (k == 0) begin
                  got0.push_back(deq_data[0]); void'(sb0.pop_front());
               end else begin
                  got1.push_back(deq_data[1]); void'(sb1.pop_front());
               end
            end
         end
      end
   end

   initial begin
      bit          a;
      logic [31:0] nv;
      reset = 1'b1; flush = '0; enq_val = '0; deq_rdy = '0;
      enq_data[0] = '0; enq_data[1] = '0;
      mcount[0] = 0; mcount[1] = 0;
      #5;
      chk("rst_count", 0, count[0], 0);
      chk("rst_deq_val", 0, deq_val[0], 0);
      chk("rst_enq_rdy", 0, enq_rdy[0], 1);
      #10 reset = 1'b0;
      started = 1;
      #2;

      // Asynchronous reset mid-cycle with two entries held
      step(0, 1, 11, 0, 0, a);
      step(0, 1, 22, 0, 0, a);
      chk("pre_rst_count", 0, count[0], 2);
      #4 reset = 1'b1;
      mcount[0] = 0; mcount[1] = 0; sb0.delete(); sb1.delete();
      #1;
      chk("arst_count", 0, count[0], 0);
      chk("arst_deq_val", 0, deq_val[0], 0);
      chk("arst_enq_rdy", 0, enq_rdy[0], 1);
      chk("arst_almost_empty", 0, almost_empty[0], 1);
      chk("arst_deq_data", 0, deq_data[0], 0);
      #2 reset = 1'b0;
      step(0, 1, 77, 0, 0, a);
      chk("post_rst_count", 0, count[0], 1);
      step(0, 0, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, a);
      chk_got("post_rst", 0, 1, 77, 0);

      // Fill past full, then drain
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 25 + 10 * i, 0, 0, a);
         chk("fill_count", 0, count[0], (i < 4) ? i + 1 : 4);
      end
      chk("full_enq_rdy", 0, enq_rdy[0], 0);
      chk("full_almost_full", 0, almost_full[0], 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, a);
      chk("drained_deq_val", 0, deq_val[0], 0);
      chk_got("fill_drain", 0, 4, 25, 10);

      // Streaming at one entry of occupancy
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 25 + 10 * i, 1, 0, a);
         chk("stream_count", 0, count[0], 1);
      end
      step(0, 0, 0, 1, 0, a);
      chk_got("stream", 0, 8, 25, 10);

      // Full with enqueue and dequeue both requested
      for (int i = 0; i < 4; i++) step(0, 1, 25 + 10 * i, 0, 0, a);
      step(0, 1, 65, 1, 0, a);
      chk("fulldeq_acc1", 0, a, 0);
      chk("fulldeq_count1", 0, count[0], 3);
      step(0, 1, 65, 1, 0, a);
      chk("fulldeq_acc2", 0, a, 1);
      chk("fulldeq_count2", 0, count[0], 3);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, a);
      chk_got("fulldeq", 0, 5, 25, 10);

      // Flush beats concurrent enq/deq
      for (int i = 0; i < 3; i++) step(0, 1, 40 + i, 0, 0, a);
      step(0, 1, 88, 1, 1, a);
      chk("flush_count", 0, count[0], 0);
      chk("flush_deq_val", 0, deq_val[0], 0);
      chk_got("flush_nopop", 0, 0, 0, 0);
      step(0, 1, 99, 0, 0, a);
      step(0, 0, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, a);
      chk_got("after_flush", 0, 1, 99, 0);

      // Random traffic on the non-power-of-2 instance
      got1.delete();
      nv = 1;
      for (int i = 0; i < 200; i++) begin
         step(1, $urandom_range(0, 1) == 1, nv, $urandom_range(0, 1) == 1, 0, a);
         if (a) nv++;
      end
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, a);
      chk("wrap_empty", 1, deq_val[1], 0);
      chk_got("wrap_order", 1, int'(nv) - 1, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
